// File: rtl/bmd_tx_arbiter.sv
// bmd_tx_arbiter: per-TLP arbiter sharing the trn_t* port between the completion and FOFB DMA engines.
// Define BMD_TX_FAIRNESS_EN to let DMA win after CPL_BURST_MAX back-to-back completions.
module bmd_tx_arbiter #(
    parameter int INTERFACE_WIDTH = 64,
    parameter int CPL_BURST_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpl_req_i,
    output logic                         cpl_gnt_o,
    input  logic [INTERFACE_WIDTH-1:0]   cpl_td_i,
    input  logic [INTERFACE_WIDTH/8-1:0] cpl_trem_n_i,
    input  logic                         cpl_tsof_n_i,
    input  logic                         cpl_teof_n_i,
    input  logic                         cpl_tsrc_rdy_n_i,
    output logic                         cpl_tdst_rdy_n_o,
    input  logic                         dma_req_i,
    output logic                         dma_gnt_o,
    input  logic [INTERFACE_WIDTH-1:0]   dma_td_i,
    input  logic [INTERFACE_WIDTH/8-1:0] dma_trem_n_i,
    input  logic                         dma_tsof_n_i,
    input  logic                         dma_teof_n_i,
    input  logic                         dma_tsrc_rdy_n_i,
    output logic                         dma_tdst_rdy_n_o,
    output logic [INTERFACE_WIDTH-1:0]   trn_td,
    output logic [INTERFACE_WIDTH/8-1:0] trn_trem_n,
    output logic                         trn_tsof_n,
    output logic                         trn_teof_n,
    output logic                         trn_tsrc_rdy_n,
    output logic                         trn_tsrc_dsc_n,
    input  logic                         trn_tdst_rdy_n,
    input  logic                         trn_tdst_dsc_n,
    input  logic [5:0]                   trn_tbuf_av,
    input  logic                         cfg_to_turnoff_n,
    output logic                         tx_abort_o,
    output logic                         tx_idle_o
);
    typedef enum logic [1:0] {IDLE, GNT_CPL, GNT_DMA} state_t;
    state_t state, state_nxt;
    logic cpl_el, dma_el, dsc, eof_beat, dma_win, abort_q;
    assign cpl_el = cpl_req_i & trn_tbuf_av[2];
    assign dma_el = dma_req_i & trn_tbuf_av[1] & cfg_to_turnoff_n;
    assign dsc = (state != IDLE) & ~trn_tdst_dsc_n;
    assign eof_beat = (state != IDLE) & ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n & ~trn_teof_n;
    assign tx_abort_o = abort_q;
`ifdef BMD_TX_FAIRNESS_EN
    localparam int CW = $clog2(CPL_BURST_MAX + 1);
    logic [CW-1:0] burst_cnt;
    logic unused_tbuf;
    assign unused_tbuf = ^{trn_tbuf_av[5:3], trn_tbuf_av[0]};
    // Only completions that finish while DMA is actually waiting count against the burst.
    always_ff @(posedge clk) begin
        if (rst)
            burst_cnt <= '0;
        else if (state == IDLE && state_nxt == GNT_DMA)
            burst_cnt <= '0;
        else if (state == GNT_CPL && eof_beat && !dsc && dma_el && burst_cnt != CW'(CPL_BURST_MAX))
            burst_cnt <= burst_cnt + CW'(1);
    end
    assign dma_win = dma_el & (burst_cnt == CW'(CPL_BURST_MAX));
`else
    logic unused_tbuf;
    assign unused_tbuf = ^{trn_tbuf_av[5:3], trn_tbuf_av[0], CPL_BURST_MAX != 0};
    assign dma_win = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            abort_q <= 1'b0;
        end else begin
            state <= state_nxt;
            abort_q <= dsc;
        end
    end
    // Discontinue takes precedence over an EOF beat in the same cycle.
    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = (cpl_el && !dma_win) ? GNT_CPL : dma_el ? GNT_DMA : IDLE;
        else if (dsc || eof_beat)
            state_nxt = IDLE;
    end
    always_comb begin
        cpl_gnt_o = (state == GNT_CPL);
        dma_gnt_o = (state == GNT_DMA);
        trn_td = cpl_gnt_o ? cpl_td_i : dma_gnt_o ? dma_td_i : '0;
        trn_trem_n = cpl_gnt_o ? cpl_trem_n_i : dma_gnt_o ? dma_trem_n_i : '0;
        trn_tsof_n = cpl_gnt_o ? cpl_tsof_n_i : dma_gnt_o ? dma_tsof_n_i : 1'b1;
        trn_teof_n = cpl_gnt_o ? cpl_teof_n_i : dma_gnt_o ? dma_teof_n_i : 1'b1;
        trn_tsrc_rdy_n = cpl_gnt_o ? cpl_tsrc_rdy_n_i : dma_gnt_o ? dma_tsrc_rdy_n_i : 1'b1;
        trn_tsrc_dsc_n = 1'b1;
        cpl_tdst_rdy_n_o = cpl_gnt_o ? trn_tdst_rdy_n : 1'b1;
        dma_tdst_rdy_n_o = dma_gnt_o ? trn_tdst_rdy_n : 1'b1;
        tx_idle_o = (state == IDLE) & (~cfg_to_turnoff_n | ~dma_req_i);
    end
endmodule

// File: tb/tb_bmd_tx_arbiter.sv
// tb_bmd_tx_arbiter: directed and randomized bench for bmd_tx_arbiter against a cycle model.
module tb_bmd_tx_arbiter;
    localparam int W = 64;
    localparam int RW = W / 8;
    localparam int BURST = 4;
`ifdef BMD_TX_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] req = '0, src_n = '1, sof_n = '1, eof_n = '1;
    logic [W-1:0] td [2] = '{default: '0};
    logic [RW-1:0] trem [2] = '{default: '0};
    logic cpl_gnt_o, dma_gnt_o, cpl_tdst_rdy_n_o, dma_tdst_rdy_n_o, tx_abort_o, tx_idle_o;
    logic [W-1:0] trn_td;
    logic [RW-1:0] trn_trem_n;
    logic trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n;
    logic trn_tdst_rdy_n = 1'b0, trn_tdst_dsc_n = 1'b1, cfg_to_turnoff_n = 1'b1;
    logic [5:0] trn_tbuf_av = 6'h3F;

    bmd_tx_arbiter #(.INTERFACE_WIDTH(W), .CPL_BURST_MAX(BURST)) dut (
        .clk(clk), .rst(rst),
        .cpl_req_i(req[0]), .cpl_gnt_o(cpl_gnt_o), .cpl_td_i(td[0]), .cpl_trem_n_i(trem[0]),
        .cpl_tsof_n_i(sof_n[0]), .cpl_teof_n_i(eof_n[0]), .cpl_tsrc_rdy_n_i(src_n[0]),
        .cpl_tdst_rdy_n_o(cpl_tdst_rdy_n_o),
        .dma_req_i(req[1]), .dma_gnt_o(dma_gnt_o), .dma_td_i(td[1]), .dma_trem_n_i(trem[1]),
        .dma_tsof_n_i(sof_n[1]), .dma_teof_n_i(eof_n[1]), .dma_tsrc_rdy_n_i(src_n[1]),
        .dma_tdst_rdy_n_o(dma_tdst_rdy_n_o),
        .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
        .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tsrc_dsc_n(trn_tsrc_dsc_n),
        .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tdst_dsc_n(trn_tdst_dsc_n), .trn_tbuf_av(trn_tbuf_av),
        .cfg_to_turnoff_n(cfg_to_turnoff_n), .tx_abort_o(tx_abort_o), .tx_idle_o(tx_idle_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_chk = 0, cyc = 0;
    int pend [2] = '{0, 0}, len [2] = '{1, 1}, len_cfg [2] = '{0, 0};
    int beat [2] = '{0, 0}, tlp [2] = '{0, 0}, gap [2] = '{0, 0}, issued [2] = '{0, 0};
    bit acc_s [2], abort_s [2], rst_s, rnd_core;
    int rise_q [2][$];
    int order_q [$], m_order [$];
    int gnt_cyc [2], beats_cnt [2], req_rise [2];
    int abort_cnt = 0, abort_at = 0;
    logic [1:0] gnt_d = '0, req_d = '0;
    int m_own = 0, m_cnt = 0;
    int m_beat [2] = '{0, 0}, m_tlp [2] = '{0, 0};
    bit m_abort = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int pick_len(input int e);
        return len_cfg[e] != 0 ? len_cfg[e] : int'($urandom_range(6, 1));
    endfunction

    // Requester engines: each beat carries {engine, tlp#, beat#} so order and duplication are visible.
    always @(posedge clk) begin
        cyc++;
        #1;
        for (int e = 0; e < 2; e++) begin
            if (rst_s || abort_s[e]) beat[e] = 0;
            else if (acc_s[e]) begin
                if (beat[e] == len[e] - 1) begin
                    beat[e] = 0; tlp[e]++; pend[e]--; len[e] = pick_len(e);
                end else beat[e]++;
            end
            req[e] = pend[e] > 0;
            src_n[e] = !(pend[e] > 0 && int'($urandom_range(99)) >= gap[e]);
            td[e] = {8'(e + 1), 24'(tlp[e]), 32'(beat[e])};
            trem[e] = RW'(beat[e] + e * 16);
            sof_n[e] = beat[e] != 0;
            eof_n[e] = beat[e] != len[e] - 1;
        end
        if (rnd_core) begin
            trn_tdst_rdy_n = $urandom_range(99) < 30;
            trn_tdst_dsc_n = !($urandom_range(99) < 3);
            cfg_to_turnoff_n = !($urandom_range(99) < 10);
            trn_tbuf_av = {3'($urandom), $urandom_range(99) < 85, $urandom_range(99) < 85, 1'($urandom)};
        end
    end

    // Observation of DUT handshakes for the engines and for directed literal checks.
    always @(negedge clk) begin
        logic [1:0] g, r;
        g = {dma_gnt_o, cpl_gnt_o};
        r = {dma_tdst_rdy_n_o, cpl_tdst_rdy_n_o};
        for (int e = 0; e < 2; e++) begin
            acc_s[e] = g[e] && !src_n[e] && !r[e] && trn_tdst_dsc_n && !rst;
            abort_s[e] = g[e] && !trn_tdst_dsc_n;
            if (g[e] && !gnt_d[e]) begin rise_q[e].push_back(cyc); order_q.push_back(e); end
            if (req[e] && !req_d[e]) req_rise[e] = cyc;
            if (g[e]) gnt_cyc[e]++;
            if (acc_s[e]) beats_cnt[e]++;
        end
        rst_s = rst;
        if (tx_abort_o === 1'b1) begin abort_cnt++; abort_at = cyc; end
        gnt_d = g;
        req_d = req;
    end

    // Reference model: owner of the port per cycle, derived from the arbitration rules.
    always @(negedge clk) begin
        int e;
        bit cel, del;
        e = m_own > 0 ? m_own - 1 : 0;
        chk("cpl_gnt", cpl_gnt_o, m_own == 1);
        chk("dma_gnt", dma_gnt_o, m_own == 2);
        chk("abort", tx_abort_o, m_abort);
        chk("idle", tx_idle_o, m_own == 0 && (!cfg_to_turnoff_n || !req[1]));
        chk("src_rdy", trn_tsrc_rdy_n, m_own != 0 ? src_n[e] : 1'b1);
        chk("sof", trn_tsof_n, m_own != 0 ? sof_n[e] : 1'b1);
        chk("eof", trn_teof_n, m_own != 0 ? eof_n[e] : 1'b1);
        chk("td", trn_td, m_own != 0 ? td[e] : '0);
        chk("trem", trn_trem_n, m_own != 0 ? trem[e] : '0);
        chk("src_dsc", trn_tsrc_dsc_n, 1'b1);
        chk("cpl_dst_rdy", cpl_tdst_rdy_n_o, m_own == 1 ? trn_tdst_rdy_n : 1'b1);
        chk("dma_dst_rdy", dma_tdst_rdy_n_o, m_own == 2 ? trn_tdst_rdy_n : 1'b1);
        if (rst) begin
            m_own = 0; m_abort = 0; m_cnt = 0; m_beat = '{0, 0};
        end else begin
            cel = req[0] && trn_tbuf_av[2];
            del = req[1] && trn_tbuf_av[1] && cfg_to_turnoff_n;
            m_abort = 0;
            if (m_own == 0) begin
                if (cel && !(FAIR && m_cnt >= BURST && del)) m_own = 1;
                else if (del) begin m_own = 2; m_cnt = 0; end
                if (m_own != 0) m_order.push_back(m_own - 1);
            end else if (!trn_tdst_dsc_n) begin
                m_abort = 1; m_own = 0; m_beat[e] = 0;
            end else if (!src_n[e] && !trn_tdst_rdy_n) begin
                chk("beat_order", trn_td, {8'(e + 1), 24'(m_tlp[e]), 32'(m_beat[e])});
                if (!eof_n[e]) begin
                    m_own = 0; m_tlp[e]++; m_beat[e] = 0;
                    if (e == 0 && del && m_cnt < BURST) m_cnt++;
                end else m_beat[e]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input int e, input int n, input int l);
        len_cfg[e] = l;
        len[e] = pick_len(e);
        pend[e] = n;
        issued[e] += n;
    endtask

    task automatic clr();
        for (int e = 0; e < 2; e++) begin
            rise_q[e].delete(); gnt_cyc[e] = 0; beats_cnt[e] = 0;
        end
        order_q.delete();
        m_order.delete();
        abort_cnt = 0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((pend[0] != 0 || pend[1] != 0) && n < budget) begin tick(); n++; end
        chk("drain", pend[0] + pend[1], 0);
        pend = '{0, 0};
        repeat (3) tick();
    endtask

    task automatic wait_beat(input int e, input int b);
        int n = 0;
        while (!((e == 0 ? cpl_gnt_o : dma_gnt_o) && beat[e] == b) && n < 100) begin tick(); n++; end
        chk("wait_beat", n < 100, 1);
    endtask

    initial begin
        int c;
        int exp_order [20];
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_idle", tx_idle_o, 1);
        chk("rst_gnt", {cpl_gnt_o, dma_gnt_o}, 0);
        chk("rst_src_rdy", trn_tsrc_rdy_n, 1);
        chk("rst_td", trn_td, 0);
        chk("rst_abort", tx_abort_o, 0);
        tick();
        rst = 1'b0;
        tick();
        // single 3-beat completion
        clr();
        start(0, 1, 3);
        wait_done(100);
        chk("t1_latency", rise_q[0].size() > 0 ? rise_q[0][0] - req_rise[0] : -1, 1);
        chk("t1_gnt_cycles", gnt_cyc[0], 3);
        chk("t1_beats", beats_cnt[0], 3);
        // priority with both requesters held
        clr();
        start(0, 10, 1);
        start(1, 10, 1);
        wait_done(500);
`ifdef BMD_TX_FAIRNESS_EN
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
`else
        exp_order = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
        chk("t2_grants", order_q.size(), 20);
        chk("t2_model_grants", m_order.size(), 20);
        for (int i = 0; i < 20; i++) begin
            chk("t2_order", i < order_q.size() ? order_q[i] : -1, exp_order[i]);
            chk("t2_model_order", i < m_order.size() ? m_order[i] : -1, exp_order[i]);
        end
        // posted buffer unavailable
        clr();
        trn_tbuf_av = 6'h3D;
        start(1, 1, 2);
        repeat (20) tick();
        chk("t3_no_gnt", gnt_cyc[1], 0);
        trn_tbuf_av = 6'h3F;
        c = cyc;
        wait_done(100);
        chk("t3_latency", rise_q[1].size() > 0 ? rise_q[1][0] : -1, c + 1);
        // discontinue on beat 2 of a 4-beat DMA TLP
        clr();
        start(1, 1, 4);
        wait_beat(1, 1);
        c = cyc;
        trn_tdst_dsc_n = 1'b0;
        tick();
        trn_tdst_dsc_n = 1'b1;
        wait_done(100);
        chk("t4_abort_cnt", abort_cnt, 1);
        chk("t4_abort_at", abort_at, c + 1);
        chk("t4_regrant", rise_q[1].size() > 1 ? rise_q[1][1] : -1, c + 2);
        chk("t4_beats", beats_cnt[1], 5);
        // turn-off during a DMA TLP
        clr();
        start(1, 2, 6);
        wait_beat(1, 2);
        cfg_to_turnoff_n = 1'b0;
        start(0, 1, 2);
        repeat (40) tick();
        chk("t5_dma_grants", rise_q[1].size(), 1);
        chk("t5_dma_left", pend[1], 1);
        chk("t5_cpl_grants", rise_q[0].size(), 1);
        chk("t5_idle", tx_idle_o, 1);
        chk("t5_abort", abort_cnt, 0);
        cfg_to_turnoff_n = 1'b1;
        wait_done(100);
        // core ready toggling during a 5-beat completion
        clr();
        start(0, 1, 5);
        for (int n = 0; n < 100 && pend[0] != 0; n++) begin
            tick();
            trn_tdst_rdy_n = ~trn_tdst_rdy_n;
        end
        trn_tdst_rdy_n = 1'b0;
        wait_done(10);
        chk("t6_cpl_beats", beats_cnt[0], 5);
        chk("t6_dma_beats", beats_cnt[1], 0);
        // randomized traffic with a reset pulse in the middle
        clr();
        gap = '{30, 30};
        rnd_core = 1'b1;
        start(0, int'($urandom_range(15, 5)), 0);
        start(1, int'($urandom_range(15, 5)), 0);
        for (int n = 0; n < 20000 && (pend[0] != 0 || pend[1] != 0); n++) begin
            tick();
            rst = (n == 300);
        end
        rst = 1'b0;
        rnd_core = 1'b0;
        trn_tdst_rdy_n = 1'b0;
        trn_tdst_dsc_n = 1'b1;
        cfg_to_turnoff_n = 1'b1;
        trn_tbuf_av = 6'h3F;
        wait_done(200);
        chk("rand_cpl_tlps", m_tlp[0], issued[0]);
        chk("rand_dma_tlps", m_tlp[1], issued[1]);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
